mipi_csi_frame_controller: RTL

Sequences the MIPI CSI-2 receive path above `mipi_csi_packet_decoder`. It gates the decoder's input-valid and parses each 32-bit packet header the decoder captures. It tracks frame/line state per CSI-2 short and long packets, counts payload words against the header word count, and flags protocol errors. It sits between the lane aligner/decoder and the pixel unpacker, and gives downstream logic clean frame/line framing.

---
 rtl/mipi_csi_pkg.sv | 43 ++++
 rtl/mipi_csi_frame_controller_if.sv | 37 +++
 rtl/mipi_csi_header_parse.sv | 23 ++
 rtl/mipi_csi_frame_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the MIPI CSI-2 receive path: data types, header
// field offsets, controller states and error bit indices.
package mipi_csi_pkg;

  // CSI-2 data type codes
  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  // Packet header field offsets, byte-ordered as on the wire
  localparam int unsigned HDR_DT_LSB  = 0;
  localparam int unsigned HDR_DT_MSB  = 5;
  localparam int unsigned HDR_VC_LSB  = 6;
  localparam int unsigned HDR_VC_MSB  = 7;
  localparam int unsigned HDR_WC_LSB  = 8;
  localparam int unsigned HDR_WC_MSB  = 23;
  localparam int unsigned HDR_ECC_LSB = 24;
  localparam int unsigned HDR_ECC_MSB = 31;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFs,
    StFrame,
    StLine
  } ctrl_state_e;

  // Sticky error bit indices
  localparam int unsigned ERR_WC      = 0;
  localparam int unsigned ERR_LINES   = 1;
  localparam int unsigned ERR_SHORT   = 2;
  localparam int unsigned ERR_TIMEOUT = 3;

  // Byte count to 4-byte payload words, rounded up; 17-bit sum avoids overflow
  function automatic logic [14:0] wc_to_words(input logic [15:0] wc);
    logic [16:0] sum;
    sum = {1'b0, wc} + 17'd3;
    return sum[16:2];
  endfunction

endpackage

// File: rtl/mipi_csi_frame_controller_if.sv
// Bus bundle between the decoder/register side (master) and the frame
// controller (slave).
interface mipi_csi_frame_controller_if #(
  parameter int unsigned LINES_W = 12
) ();
  logic               enable_i;
  logic               hdr_valid_i;
  logic [31:0]        hdr_i;
  logic               payload_valid_i;
  logic [15:0]        expected_wc_i;
  logic [LINES_W-1:0] expected_lines_i;
  logic               err_clear_i;

  logic               decoder_enable_o;
  logic               frame_active_o;
  logic               line_valid_o;
  logic               frame_start_o;
  logic               frame_end_o;
  logic               line_end_o;
  logic [LINES_W-1:0] line_count_o;
  logic [15:0]        frame_count_o;
  logic [3:0]         err_o;

  modport master (
    output enable_i, hdr_valid_i, hdr_i, payload_valid_i, expected_wc_i,
           expected_lines_i, err_clear_i,
    input  decoder_enable_o, frame_active_o, line_valid_o, frame_start_o,
           frame_end_o, line_end_o, line_count_o, frame_count_o, err_o
  );

  modport slave (
    input  enable_i, hdr_valid_i, hdr_i, payload_valid_i, expected_wc_i,
           expected_lines_i, err_clear_i,
    output decoder_enable_o, frame_active_o, line_valid_o, frame_start_o,
           frame_end_o, line_end_o, line_count_o, frame_count_o, err_o
  );
endinterface

// File: rtl/mipi_csi_header_parse.sv
// Combinational split of a CSI-2 packet header into VC/DT/WC/ECC plus the
// payload word count derived from the byte count.
module mipi_csi_header_parse
  import mipi_csi_pkg::*;
(
  input  logic [31:0] hdr,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic [7:0]  ecc,
  output logic [14:0] words
);

  // Field extraction and word count
  always_comb begin
    vc    = hdr[HDR_VC_MSB:HDR_VC_LSB];
    dt    = hdr[HDR_DT_MSB:HDR_DT_LSB];
    wc    = hdr[HDR_WC_MSB:HDR_WC_LSB];
    ecc   = hdr[HDR_ECC_MSB:HDR_ECC_LSB];
    words = wc_to_words(hdr[HDR_WC_MSB:HDR_WC_LSB]);
  end

endmodule

// File: rtl/mipi_csi_frame_controller.sv
// CSI-2 frame/line sequencer above the packet decoder: gates the decoder,
// tracks FS/line/FE framing, counts payload words and flags sticky errors.
// Optional idle watchdog: define MIPI_CSI_FRAME_CTRL_TIMEOUT_EN.
module mipi_csi_frame_controller
  import mipi_csi_pkg::*;
#(
  parameter logic [1:0]  VC       = 2'd0,
  parameter logic [5:0]  DT_PIXEL = 6'h2B,
  parameter int unsigned LINES_W  = 12
`ifdef MIPI_CSI_FRAME_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  mipi_csi_frame_controller_if.slave bus
);

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [14:0] hdr_words;
  logic [7:0]  unused_ecc;

  mipi_csi_header_parse u_parse (
    .hdr   (bus.hdr_i),
    .vc    (hdr_vc),
    .dt    (hdr_dt),
    .wc    (hdr_wc),
    .ecc   (unused_ecc),
    .words (hdr_words)
  );

  ctrl_state_e        state;
  logic               decoder_enable;
  logic               frame_active;
  logic               line_valid;
  logic               frame_start;
  logic               frame_end;
  logic               line_end;
  logic [LINES_W-1:0] line_count;
  logic [15:0]        frame_count;
  logic [3:0]         err;
  logic [14:0]        words_left;

  logic               is_fs;
  logic               is_fe;
  logic               is_pix;
  logic [LINES_W-1:0] line_count_inc;
  logic               timeout;

  // Header classification for the accepted virtual channel
  always_comb begin
    is_fs          = (hdr_vc == VC) && (hdr_dt == DT_FS);
    is_fe          = (hdr_vc == VC) && (hdr_dt == DT_FE);
    is_pix         = (hdr_vc == VC) && (hdr_dt == DT_PIXEL);
    line_count_inc = (line_count == '1) ? line_count : line_count + 1'b1;
  end

`ifdef MIPI_CSI_FRAME_CTRL_TIMEOUT_EN
  logic [15:0] watchdog;
  logic        in_frame;
  logic        any_valid;

  // Watchdog fires on the TIMEOUT_CYCLES-th consecutive idle cycle in a frame
  always_comb begin
    in_frame  = (state == StFrame) || (state == StLine);
    any_valid = bus.hdr_valid_i || bus.payload_valid_i;
    timeout   = in_frame && !any_valid && (watchdog == 16'(TIMEOUT_CYCLES - 1));
  end

  // Idle-cycle counter, cleared by any valid or outside a frame
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      watchdog <= '0;
    end else if (!in_frame || any_valid || timeout) begin
      watchdog <= '0;
    end else begin
      watchdog <= watchdog + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Main sequencer with registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= StIdle;
      decoder_enable <= 1'b0;
      frame_active   <= 1'b0;
      line_valid     <= 1'b0;
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
      line_end       <= 1'b0;
      line_count     <= '0;
      frame_count    <= '0;
      err            <= '0;
      words_left     <= '0;
    end else begin
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
      line_end       <= 1'b0;
      decoder_enable <= (state != StIdle);
      // Later per-bit sets override this, so a same-cycle error survives a clear
      if (bus.err_clear_i) err <= '0;

      unique case (state)
        StIdle: begin
          if (bus.enable_i) state <= StWaitFs;
        end
        StWaitFs: begin
          if (!bus.enable_i) begin
            state <= StIdle;
          end else if (bus.hdr_valid_i && is_fs) begin
            frame_start  <= 1'b1;
            frame_active <= 1'b1;
            line_count   <= '0;
            state        <= StFrame;
          end
        end
        StFrame, StLine: begin
          if (bus.hdr_valid_i) begin
            // A header mid-line abandons it; the header itself is still handled
            if (state == StLine) begin
              err[ERR_SHORT] <= 1'b1;
              line_valid     <= 1'b0;
              state          <= StFrame;
            end
            if (is_pix) begin
              words_left <= hdr_words;
              if (hdr_wc != bus.expected_wc_i) err[ERR_WC] <= 1'b1;
              if (hdr_wc == 16'd0) begin
                line_end   <= 1'b1;
                line_count <= line_count_inc;
                line_valid <= 1'b0;
                state      <= StFrame;
              end else begin
                line_valid <= 1'b1;
                state      <= StLine;
              end
            end else if (is_fe) begin
              frame_end    <= 1'b1;
              frame_count  <= frame_count + 16'd1;
              frame_active <= 1'b0;
              line_valid   <= 1'b0;
              if (line_count != bus.expected_lines_i) err[ERR_LINES] <= 1'b1;
              state <= bus.enable_i ? StWaitFs : StIdle;
            end
          end else if (timeout) begin
            err[ERR_TIMEOUT] <= 1'b1;
            frame_end        <= 1'b1;
            frame_active     <= 1'b0;
            line_valid       <= 1'b0;
            state            <= bus.enable_i ? StWaitFs : StIdle;
          end else if ((state == StLine) && bus.payload_valid_i) begin
            if (words_left == 15'd1) begin
              line_end   <= 1'b1;
              line_count <= line_count_inc;
              line_valid <= 1'b0;
              state      <= StFrame;
            end else begin
              words_left <= words_left - 15'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.decoder_enable_o = decoder_enable;
  assign bus.frame_active_o   = frame_active;
  assign bus.line_valid_o     = line_valid;
  assign bus.frame_start_o    = frame_start;
  assign bus.frame_end_o      = frame_end;
  assign bus.line_end_o       = line_end;
  assign bus.line_count_o     = line_count;
  assign bus.frame_count_o    = frame_count;
  assign bus.err_o            = err;

endmodule
